sobel_stream_nch: RTL and testbench

//  Parametrised streaming 3x3 Sobel edge detector; N independent colour channels.

---
 rtl/sobel_stream_nch_if.sv | 15 +
 rtl/sobel_stream_nch.sv | 166 ++++++++++++++++
 tb/tb_sobel_stream_nch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_nch_if.sv
// Valid/ready pixel stream carrying CH*CW packed data, a start-of-frame flag and a user sideband.
// The master drives the payload and the slave answers with ready.
interface sobel_stream_nch_if #(
    parameter int DW = 18,
    parameter int UW = 1
) ();
    logic          valid;
    logic          ready;
    logic          sof;
    logic [DW-1:0] data;
    logic [UW-1:0] user;

    modport master (output valid, sof, data, user, input ready);
    modport slave  (input valid, sof, data, user, output ready);
endinterface

// File: rtl/sobel_stream_nch.sv
// Streaming 3x3 Sobel edge magnitude over CH channels; 3-stage pipeline, one beat out per beat in.
// Optional macro SOBEL_THRESH_EN adds cfg_thresh and binarises each channel against it.
module sobel_stream_nch #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int CH        = 3,
    parameter int CW        = 6,
    parameter int USER_W    = 1,
    parameter int OUT_SHIFT = 2
) (
    input  logic               clk_w,
    input  logic               rst,
`ifdef SOBEL_THRESH_EN
    input  logic [CW-1:0]      cfg_thresh,
`endif
    sobel_stream_nch_if.slave  in_if,
    sobel_stream_nch_if.master out_if
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int GW = CW + 3;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO   = XW'(2);
    localparam logic [YW-1:0] Y_TWO   = YW'(2);
    localparam logic [GW:0]   SAT_MAX = (GW + 1)'((1 << CW) - 1);

    logic              en;
    logic              accept;
    logic [XW-1:0]     x_reg, x_next, pos_x;
    logic [YW-1:0]     y_reg, y_next, pos_y;

    logic              s1_valid_reg, s1_inner_reg;
    logic [XW-1:0]     s1_x_reg;
    logic [USER_W-1:0] s1_user_reg;
    logic              s2_valid_reg, s2_inner_reg;
    logic [USER_W-1:0] s2_user_reg;
    logic              out_valid_reg;
    logic [CH*CW-1:0]  out_data_reg;
    logic [USER_W-1:0] out_user_reg;
    logic [CH*CW-1:0]  res_data;
    logic [CW-1:0]     res_arr [CH];

    assign en           = !out_valid_reg || out_if.ready;
    assign accept       = in_if.valid && en;
    assign in_if.ready  = en;
    assign out_if.valid = out_valid_reg;
    assign out_if.data  = out_data_reg;
    assign out_if.user  = out_user_reg;
    assign out_if.sof   = 1'b0;

    // A start-of-frame beat is placed at (0,0) regardless of where the counters were.
    always_comb begin
        pos_x  = in_if.sof ? '0 : x_reg;
        pos_y  = in_if.sof ? '0 : y_reg;
        x_next = (pos_x == X_LAST) ? '0 : pos_x + 1'b1;
        y_next = pos_y;
        if (pos_x == X_LAST) begin
            y_next = (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
        end
    end

    always_ff @(posedge clk_w) begin
        if (rst) begin
            x_reg         <= '0;
            y_reg         <= '0;
            s1_valid_reg  <= 1'b0;
            s1_inner_reg  <= 1'b0;
            s1_x_reg      <= '0;
            s1_user_reg   <= '0;
            s2_valid_reg  <= 1'b0;
            s2_inner_reg  <= 1'b0;
            s2_user_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_user_reg  <= '0;
        end else if (en) begin
            s1_valid_reg  <= accept;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            if (accept) begin
                x_reg        <= x_next;
                y_reg        <= y_next;
                s1_x_reg     <= pos_x;
                s1_inner_reg <= (pos_x >= X_TWO) && (pos_y >= Y_TWO);
                s1_user_reg  <= in_if.user;
            end
            if (s1_valid_reg) begin
                s2_inner_reg <= s1_inner_reg;
                s2_user_reg  <= s1_user_reg;
            end
            if (s2_valid_reg) begin
                out_data_reg <= res_data;
                out_user_reg <= s2_user_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [CW-1:0]        lb0_mem [IMG_W];
            logic [CW-1:0]        lb1_mem [IMG_W];
            logic [CW-1:0]        pix_reg, rd0_reg, rd1_reg;
            logic [CW-1:0]        w0_reg [3];
            logic [CW-1:0]        w1_reg [3];
            logic signed [GW-1:0] gx_reg, gy_reg;
            logic [GW-1:0]        left_sum, right_sum, top_sum, bot_sum;
            logic [GW-1:0]        abs_x, abs_y;
            logic [GW:0]          mag, scaled;
            logic [CW-1:0]        sat, val;

            // lb0 holds line y-1; lb1 (line y-2) is refilled one stage later from lb0's read data.
            always_ff @(posedge clk_w) begin
                if (accept) begin
                    rd0_reg        <= lb0_mem[pos_x];
                    rd1_reg        <= lb1_mem[pos_x];
                    pix_reg        <= in_if.data[gi*CW +: CW];
                    lb0_mem[pos_x] <= in_if.data[gi*CW +: CW];
                end
                if (en && s1_valid_reg) begin
                    lb1_mem[s1_x_reg] <= rd0_reg;
                end
            end

            // Window columns: w0 = x-2, w1 = x-1, stage-1 column = x; index 0 is the oldest row.
            always_comb begin
                left_sum  = GW'(w0_reg[0]) + GW'({w0_reg[1], 1'b0}) + GW'(w0_reg[2]);
                right_sum = GW'(rd1_reg)   + GW'({rd0_reg, 1'b0})   + GW'(pix_reg);
                top_sum   = GW'(w0_reg[0]) + GW'({w1_reg[0], 1'b0}) + GW'(rd1_reg);
                bot_sum   = GW'(w0_reg[2]) + GW'({w1_reg[2], 1'b0}) + GW'(pix_reg);
            end

            always_ff @(posedge clk_w) begin
                if (en && s1_valid_reg) begin
                    w0_reg <= w1_reg;
                    w1_reg <= '{rd1_reg, rd0_reg, pix_reg};
                    gx_reg <= signed'(right_sum - left_sum);
                    gy_reg <= signed'(bot_sum - top_sum);
                end
            end

            always_comb begin
                abs_x  = gx_reg[GW-1] ? $unsigned(-gx_reg) : $unsigned(gx_reg);
                abs_y  = gy_reg[GW-1] ? $unsigned(-gy_reg) : $unsigned(gy_reg);
                mag    = (GW + 1)'(abs_x) + (GW + 1)'(abs_y);
                scaled = mag >> OUT_SHIFT;
                sat    = (scaled > SAT_MAX) ? '1 : scaled[CW-1:0];
                val    = s2_inner_reg ? sat : '0;
            end

`ifdef SOBEL_THRESH_EN
            assign res_arr[gi] = (val >= cfg_thresh) ? '1 : '0;
`else
            assign res_arr[gi] = val;
`endif
        end
    endgenerate

    always_comb begin
        res_data = '0;
        for (int c = 0; c < CH; c++) begin
            res_data[c*CW +: CW] = res_arr[c];
        end
    end
endmodule

// File: tb/tb_sobel_stream_nch.sv
// Randomised and directed stream bench for sobel_stream_nch; two instances (shift 0 and 3)
// share one input stream and are scored against an image-array Sobel model.
module tb_sobel_stream_nch;
    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int CH    = 3;
    localparam int CW    = 6;
    localparam int UW    = 2;
    localparam int DW    = CH * CW;

    logic clk_w = 1'b0;
    logic rst   = 1'b1;
    always #5 clk_w = ~clk_w;

    logic          in_valid  = 1'b0;
    logic          in_sof    = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic [UW-1:0] in_user   = '0;
    logic          out_ready = 1'b1;
`ifdef SOBEL_THRESH_EN
    logic [CW-1:0] cfg_thresh = 6'd40;
`endif

    sobel_stream_nch_if #(.DW(DW), .UW(UW)) ia ();
    sobel_stream_nch_if #(.DW(DW), .UW(UW)) oa ();
    sobel_stream_nch_if #(.DW(DW), .UW(UW)) ib ();
    sobel_stream_nch_if #(.DW(DW), .UW(UW)) ob ();

    assign ia.valid = in_valid;
    assign ia.sof   = in_sof;
    assign ia.data  = in_data;
    assign ia.user  = in_user;
    assign ib.valid = in_valid;
    assign ib.sof   = in_sof;
    assign ib.data  = in_data;
    assign ib.user  = in_user;
    assign oa.ready = out_ready;
    assign ob.ready = out_ready;

    sobel_stream_nch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .CW(CW), .USER_W(UW), .OUT_SHIFT(0)) dut_a (
        .clk_w(clk_w), .rst(rst),
`ifdef SOBEL_THRESH_EN
        .cfg_thresh(cfg_thresh),
`endif
        .in_if(ia), .out_if(oa));

    sobel_stream_nch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .CW(CW), .USER_W(UW), .OUT_SHIFT(3)) dut_b (
        .clk_w(clk_w), .rst(rst),
`ifdef SOBEL_THRESH_EN
        .cfg_thresh(cfg_thresh),
`endif
        .in_if(ib), .out_if(ob));

    typedef struct {
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic [UW-1:0] u;
    } exp_t;

    int   img [IMG_H][IMG_W][CH];
    int   mx = 0, my = 0;
    exp_t expq[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, stall_lo = -1, stall_hi = -1;
    bit   rand_ready = 0, gap_en = 0, accepted = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat63(input int v);
        return (v > 63) ? 63 : v;
    endfunction

    // Reference: place the pixel in a frame image, then apply the Sobel kernels to the
    // 3x3 neighbourhood ending at the pixel (centre one up and one left).
    task automatic model_accept(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic s);
        int   px, py, gx, gy, m, va, vb;
        int   p [3][3];
        exp_t e;
        logic [31:0] wa, wb;
        px = s ? 0 : mx;
        py = s ? 0 : my;
        for (int c = 0; c < CH; c++) img[py][px][c] = int'(d[c*CW +: CW]);
        e.da = '0;
        e.db = '0;
        e.u  = u;
        for (int c = 0; c < CH; c++) begin
            va = 0;
            vb = 0;
            if (px >= 2 && py >= 2) begin
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        p[r][k] = img[py-2+r][px-2+k][c];
                gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
                gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
                m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                va = sat63(m);
                vb = sat63(m >> 3);
            end
`ifdef SOBEL_THRESH_EN
            va = (va >= int'(cfg_thresh)) ? 63 : 0;
            vb = (vb >= int'(cfg_thresh)) ? 63 : 0;
`endif
            wa = 32'(va);
            wb = 32'(vb);
            e.da[c*CW +: CW] = wa[CW-1:0];
            e.db[c*CW +: CW] = wb[CW-1:0];
        end
        expq.push_back(e);
        mx = px + 1;
        my = py;
        if (mx == IMG_W) begin
            mx = 0;
            my = (py + 1 == IMG_H) ? 0 : py + 1;
        end
    endtask

    // One clock: score at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk_w);
        if (!rst) begin
            check("in_ready", 64'(ia.ready), 64'(!oa.valid || out_ready));
            check("valid_b", 64'(ob.valid), 64'(oa.valid));
            if (oa.valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_beat", 64'(oa.valid), 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("data_a", 64'(oa.data), 64'(e.da));
                    check("data_b", 64'(ob.data), 64'(e.db));
                    check("user", 64'(oa.user), 64'(e.u));
                end
            end
            if (in_valid && ia.ready) begin
                model_accept(in_data, in_user, in_sof);
                accepted = 1;
            end
        end
        @(posedge clk_w);
        #1;
        cyc++;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    endtask

    task automatic send_pixel(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_user  = u;
        in_sof   = s;
        accepted = 0;
        for (int t = 0; t < 64 && !accepted; t++) tick();
        if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (gap_en && $urandom_range(0, 3) == 0) tick();
    endtask

    // kind 0: flat 20, 1: vertical step at column 4, 2: random pixels.
    task automatic send_frame(input int kind, input int n, input int sof_at);
        logic [DW-1:0] d;
        logic [CW-1:0] v;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CH; c++) begin
                case (kind)
                    0:       v = 6'd20;
                    1:       v = ((b % IMG_W) < 4) ? 6'd0 : 6'd63;
                    default: v = CW'($urandom_range(0, 63));
                endcase
                d[c*CW +: CW] = v;
            end
            send_pixel(d, UW'($urandom_range(0, 3)), b == sof_at);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && expq.size() > 0; t++) tick();
        check("drain_left", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_w);
        #1;
        rst = 1'b0;
        @(negedge clk_w);
        check("rst_out_valid", 64'(oa.valid), 64'd0);
        check("rst_out_data", 64'(oa.data), 64'd0);
        check("rst_out_user", 64'(oa.user), 64'd0);
        check("rst_in_ready", 64'(ia.ready), 64'd1);
        @(posedge clk_w);
        #1;

        send_frame(0, 32, 0);          // flat frame
        drain();
        send_frame(1, 32, 0);          // vertical step
        drain();

        stall_lo = cyc + 10;           // step frame with a 5-cycle output stall
        stall_hi = cyc + 14;
        send_frame(1, 32, 0);
        drain();
        stall_lo = -1;
        stall_hi = -1;

        send_frame(2, 13, 0);          // sof on beat 13, then a frame without sof
        send_frame(1, 32, 0);
        send_frame(2, 32, -1);
        drain();

        rand_ready = 1;                // random back-pressure and input gaps
        gap_en     = 1;
        repeat (3) send_frame(2, 32, 0);
        drain();
        rand_ready = 0;
        gap_en     = 0;
        out_ready  = 1'b1;

        send_frame(2, 10, 0);          // reset pulse mid-frame
        rst = 1'b1;
        @(posedge clk_w);
        #1;
        rst = 1'b0;
        expq.delete();
        mx = 0;
        my = 0;
        @(negedge clk_w);
        check("midrst_out_valid", 64'(oa.valid), 64'd0);
        @(posedge clk_w);
        #1;
        send_frame(1, 32, -1);
        drain();

`ifdef SOBEL_THRESH_EN
        cfg_thresh = 6'd40;
        send_frame(1, 32, 0);
        drain();
        cfg_thresh = 6'h3F;
        send_frame(1, 32, 0);
        drain();
        cfg_thresh = 6'd0;
        send_frame(1, 32, 0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
